// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode and FSM encodings shared by the ALU family.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] c_OP_ADD = 4'd0;
  localparam logic [3:0] c_OP_SUB = 4'd1;
  localparam logic [3:0] c_OP_MUL = 4'd2;
  localparam logic [3:0] c_OP_DIV = 4'd3;
  localparam logic [3:0] c_OP_AND = 4'd4;
  localparam logic [3:0] c_OP_OR  = 4'd5;
  localparam logic [3:0] c_OP_XOR = 4'd6;
  localparam logic [3:0] c_OP_LS  = 4'd7;
  localparam logic [3:0] c_OP_RS  = 4'd8;
  localparam logic [3:0] c_OP_EQ  = 4'd9;
  localparam logic [3:0] c_OP_NEQ = 4'd10;
  localparam logic [3:0] c_OP_LT  = 4'd11;
  localparam logic [3:0] c_OP_LTE = 4'd12;
  localparam logic [3:0] c_OP_GT  = 4'd13;
  localparam logic [3:0] c_OP_GTE = 4'd14;
  localparam logic [3:0] c_OP_INV = 4'd15;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_BUSY = 2'd1;
  localparam logic [1:0] c_ST_DONE = 2'd2;

  function automatic logic isMulDiv(input logic [3:0] op);
    return (op == c_OP_MUL) || (op == c_OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/iter_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : iter_muldiv
// Description : One-bit-per-cycle shift-add multiplier / restoring divider on
//               operand magnitudes; sign fix-up is left to the caller.
// Revision    : 1.0 - initial release
// ============================================================================
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             flush,
  input  logic             op,
  input  logic             isSigned,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             done,
  output logic [WIDTH-1:0] resLo,
  output logic [WIDTH-1:0] resHi
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opB;
  logic             r_isDiv;
  logic             r_active;
  logic [CW-1:0]    r_count;

  logic [WIDTH-1:0] w_magA;
  logic [WIDTH-1:0] w_magB;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_nextHi;
  logic [WIDTH-1:0] w_nextLo;

  assign w_magA = (isSigned && srcA[WIDTH-1]) ? -srcA : srcA;
  assign w_magB = (isSigned && srcB[WIDTH-1]) ? -srcB : srcB;

  // The divide compare can be done on WIDTH+1 bits because remainder < divisor.
  always_comb begin
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opB} : '0);
    w_shift  = {r_hi, r_lo[WIDTH-1]};
    w_ge     = (w_shift >= {1'b0, r_opB});
    w_diff   = w_shift[WIDTH-1:0] - r_opB;
    w_nextHi = '0;
    w_nextLo = '0;
    if (r_isDiv) begin
      w_nextHi = w_ge ? w_diff : w_shift[WIDTH-1:0];
      w_nextLo = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_nextHi = w_sum[WIDTH:1];
      w_nextLo = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_opB    <= '0;
      r_isDiv  <= 1'b0;
      r_active <= 1'b0;
      r_count  <= '0;
    end else if (flush) begin
      r_active <= 1'b0;
      r_count  <= '0;
    end else if (start) begin
      r_hi     <= '0;
      r_lo     <= w_magA;
      r_opB    <= w_magB;
      r_isDiv  <= op;
      r_active <= 1'b1;
      r_count  <= '0;
    end else if (r_active) begin
      r_hi <= w_nextHi;
      r_lo <= w_nextLo;
      if (r_count == c_LAST) begin
        r_active <= 1'b0;
        r_count  <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  // The final iteration's next-state is exposed so the caller can register it
  // on the same edge the iteration completes.
  assign done  = r_active && (r_count == c_LAST);
  assign resLo = w_nextLo;
  assign resHi = w_nextHi;

endmodule
`default_nettype wire

// File: rtl/iterative_alu.sv
`default_nettype none
// ============================================================================
// Module      : iterative_alu
// Description : Multi-cycle ALU behind a valid/ready handshake; single-cycle
//               ops finish in one cycle, MUL/DIV iterate for WIDTH cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module iterative_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluControl,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluResult,
  output logic [WIDTH-1:0] aluResultHi,
  output logic             divByZero
);

  localparam int SHW = $clog2(WIDTH);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_resultHi;
  logic             r_divByZero;
  logic             r_isDiv;
  logic             r_negRes;
  logic             r_negRem;
  logic             r_bZero;
  logic [WIDTH-1:0] r_srcA;

  logic             w_accept;
  logic             w_startMd;
  logic             w_mdDone;
  logic [WIDTH-1:0] w_mdLo;
  logic [WIDTH-1:0] w_mdHi;
  logic [WIDTH-1:0] w_single;
  logic             w_lt;
  logic             w_eq;
  logic [SHW-1:0]   w_shamt;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prodFix;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  assign w_accept  = (r_state == c_ST_IDLE) && in_valid && !flush;
  assign w_startMd = w_accept && isMulDiv(aluControl);

  iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .resetn   (resetn),
    .start    (w_startMd),
    .flush    (flush),
    .op       (aluControl == c_OP_DIV),
    .isSigned (is_signed),
    .srcA     (srcA),
    .srcB     (srcB),
    .done     (w_mdDone),
    .resLo    (w_mdLo),
    .resHi    (w_mdHi)
  );

  assign w_shamt = srcB[SHW-1:0];
  assign w_eq    = (srcA == srcB);
  assign w_lt    = is_signed ? ($signed(srcA) < $signed(srcB)) : (srcA < srcB);

  always_comb begin
    w_single = '0;
    case (aluControl)
      c_OP_ADD: w_single = srcA + srcB;
      c_OP_SUB: w_single = srcA - srcB;
      c_OP_AND: w_single = srcA & srcB;
      c_OP_OR:  w_single = srcA | srcB;
      c_OP_XOR: w_single = srcA ^ srcB;
      c_OP_LS:  w_single = srcA << w_shamt;
      c_OP_RS:  w_single = is_signed ? $unsigned($signed(srcA) >>> w_shamt) : (srcA >> w_shamt);
      c_OP_EQ:  w_single = WIDTH'(w_eq);
      c_OP_NEQ: w_single = WIDTH'(!w_eq);
      c_OP_LT:  w_single = WIDTH'(w_lt);
      c_OP_LTE: w_single = WIDTH'(w_lt || w_eq);
      c_OP_GT:  w_single = WIDTH'(!(w_lt || w_eq));
      c_OP_GTE: w_single = WIDTH'(!w_lt);
      default:  w_single = '0;
    endcase
  end

  // Most-negative / -1 falls out naturally: magnitude quotient 2^(W-1) negates to itself.
  assign w_prod    = {w_mdHi, w_mdLo};
  assign w_prodFix = r_negRes ? -w_prod : w_prod;
  assign w_quot    = r_bZero ? '1 : (r_negRes ? -w_mdLo : w_mdLo);
  assign w_rem     = r_bZero ? r_srcA : (r_negRem ? -w_mdHi : w_mdHi);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= c_ST_IDLE;
      r_result    <= '0;
      r_resultHi  <= '0;
      r_divByZero <= 1'b0;
      r_isDiv     <= 1'b0;
      r_negRes    <= 1'b0;
      r_negRem    <= 1'b0;
      r_bZero     <= 1'b0;
      r_srcA      <= '0;
    end else if (flush) begin
      r_state <= c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (in_valid) begin
            r_isDiv  <= (aluControl == c_OP_DIV);
            r_negRes <= is_signed && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
            r_negRem <= is_signed && srcA[WIDTH-1];
            r_bZero  <= (srcB == '0);
            r_srcA   <= srcA;
            if (isMulDiv(aluControl)) begin
              r_state <= c_ST_BUSY;
            end else begin
              r_result    <= w_single;
              r_resultHi  <= '0;
              r_divByZero <= 1'b0;
              r_state     <= c_ST_DONE;
            end
          end
        end
        c_ST_BUSY: begin
          if (w_mdDone) begin
            if (r_isDiv) begin
              r_result    <= w_quot;
              r_resultHi  <= w_rem;
              r_divByZero <= r_bZero;
            end else begin
              r_result    <= w_prodFix[WIDTH-1:0];
              r_resultHi  <= w_prodFix[2*WIDTH-1:WIDTH];
              r_divByZero <= 1'b0;
            end
            r_state <= c_ST_DONE;
          end
        end
        c_ST_DONE: begin
          if (out_ready) r_state <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign in_ready    = resetn && (r_state == c_ST_IDLE);
  assign out_valid   = (r_state == c_ST_DONE);
  assign aluResult   = r_result;
  assign aluResultHi = r_resultHi;
  assign divByZero   = r_divByZero;

endmodule
`default_nettype wire
